// File: rtl/jace_vram_arbiter.sv
// Video RAM time-slot arbiter for the Jupiter Ace style display.
// One single-port 2 KB RAM (screen 1 KB + char 1 KB) is shared by the video
// fetch and the Z80. In each 8-clock character cell the video owns the
// early phases (screen byte, then char-pattern byte); the CPU gets the rest,
// or every phase outside the active display. The RAM read port is
// registered, so the address driven in one clock returns data in the next.
// That is why the char address can be formed from mem_rdata in phase 1.
module jace_vram_arbiter #(
  parameter int CPU_FIRST_PHASE = 2,
  parameter int ADDR_W          = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              viden,
  input  logic [2:0]        cell_phase,
  input  logic [ADDR_W-2:0] vid_scr_addr,
  input  logic [2:0]        vid_chr_row,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              wait_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        vid_scr_data,
  output logic [7:0]        vid_chr_data,
  output logic              vid_load
);

  localparam logic [2:0] CPU_PH = 3'(CPU_FIRST_PHASE);
  // Char-pattern index bits taken from the screen byte (bit 7 is inverse).
  localparam int         CHR_HI = ADDR_W - 5;

  typedef enum logic [1:0] {IDLE, CAPT, HOLD} state_t;

  state_t state;
  logic   fetch_act;  // a cell fetch started at phase 0 and is still in flight
  logic   rd_pend;    // access issued from IDLE was a read
  logic   vid_ph0;    // video owns the port: screen address
  logic   vid_ph1;    // video owns the port: char address
  logic   slot_free;
  logic   cpu_go;     // CPU access is issued this clock

  assign vid_ph0   = viden && (cell_phase == 3'd0);
  assign vid_ph1   = fetch_act && (cell_phase == 3'd1);
  assign slot_free = (!viden || (cell_phase >= CPU_PH)) && !vid_ph0 && !vid_ph1;
  assign cpu_go    = (state == IDLE) && cpu_req && slot_free;

  // The Z80 is stretched until the access is issued and its data captured.
  assign wait_n = rst ? 1'b1 : !(cpu_req && (state != HOLD));

  // RAM port mux: video first, then a CPU access issued from IDLE.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (!rst) begin
      if (vid_ph0) begin
        mem_addr = {1'b0, vid_scr_addr};
      end else if (vid_ph1) begin
        mem_addr = {1'b1, mem_rdata[CHR_HI:0], vid_chr_row};
      end else if (cpu_go) begin
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;
        mem_wdata = cpu_wdata;
      end
    end
  end

  // CPU access sequencer: issue, capture read data, hold until cpu_req drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_pend   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_go) begin
            state   <= CAPT;
            rd_pend <= !cpu_we;
          end
        end
        CAPT: begin
          // Data for the address issued last clock is on mem_rdata now;
          // the access completes even if cpu_req has already dropped.
          if (rd_pend) cpu_rdata <= mem_rdata;
          state <= HOLD;
        end
        HOLD: begin
          if (!cpu_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Video fetch: latch screen byte in phase 1, char byte in phase 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_act    <= 1'b0;
      vid_scr_data <= '0;
      vid_chr_data <= '0;
      vid_load     <= 1'b0;
    end else begin
      vid_load <= 1'b0;
      if (vid_ph0) begin
        fetch_act <= 1'b1;
      end else if (fetch_act) begin
        case (cell_phase)
          3'd1: vid_scr_data <= mem_rdata;
          3'd2: begin
            vid_chr_data <= mem_rdata;
            vid_load     <= 1'b1;
            fetch_act    <= 1'b0;
          end
          // Phase counter jumped past the fetch window: drop the stale fetch.
          default: fetch_act <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jace_vram_arbiter.sv
// Bench for jace_vram_arbiter: registered-read RAM model, free-running cell
// phase, directed scenarios then randomized CPU traffic. Expectations come
// from a shadow memory plus the cell slot rules (video owns phases 0-1 of a
// cell whose phase 0 saw viden; the CPU waits for the first free phase).
module tb_jace_vram_arbiter;

  logic        clk;
  logic        rst;
  logic        viden;
  logic [2:0]  cell_phase;
  logic [9:0]  vid_scr_addr;
  logic [2:0]  vid_chr_row;
  logic        cpu_req;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        wait_n;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  vid_scr_data;
  logic [7:0]  vid_chr_data;
  logic        vid_load;

  jace_vram_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .viden        (viden),
    .cell_phase   (cell_phase),
    .vid_scr_addr (vid_scr_addr),
    .vid_chr_row  (vid_chr_row),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .wait_n       (wait_n),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .vid_scr_data (vid_scr_data),
    .vid_chr_data (vid_chr_data),
    .vid_load     (vid_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with a preload port; read data registered one clock after address.
  logic [7:0]  ram [0:2047];
  logic        ld_en;
  logic [10:0] ld_addr;
  logic [7:0]  ld_data;
  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int         total;
  int         bad;
  logic [7:0] model_mem [0:2047];
  logic [2:0] ph;
  bit         rnd_vid;
  bit         f0, f1, ld_next;
  logic [7:0] exp_scr, exp_chr, last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start of a clock: advance the cell phase, optionally new cell inputs.
  task automatic step();
    @(posedge clk); #1;
    ph = ph + 3'd1;
    cell_phase = ph;
    if (rnd_vid && ph == 3'd0) begin
      vid_scr_addr = 10'($urandom);
      vid_chr_row  = 3'($urandom);
    end
  endtask

  // Mid-clock sample: video load check plus cell fetch bookkeeping.
  task automatic look();
    #5;
    if (rst) begin
      f0 = 0; f1 = 0; ld_next = 0;
    end else begin
      chk("vid_load", 32'(vid_load), 32'(ld_next));
      if (ld_next) begin
        chk("vid_scr_data", 32'(vid_scr_data), 32'(exp_scr));
        chk("vid_chr_data", 32'(vid_chr_data), 32'(exp_chr));
      end
      ld_next = 0;
      if (ph == 3'd2 && f1) begin ld_next = 1; f1 = 0; end
      if (ph == 3'd1 && f0) begin
        exp_chr = model_mem[{1'b1, exp_scr[6:0], vid_chr_row}];
        f1 = 1; f0 = 0;
      end
      if (ph == 3'd0 && viden) begin
        exp_scr = model_mem[{1'b0, vid_scr_addr}];
        f0 = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin step(); look(); end
  endtask

  // Leaves the bench just after step() with ph == p (no look yet).
  task automatic go_to(input logic [2:0] p);
    step();
    for (int k = 0; k < 8 && ph != p; k++) begin look(); step(); end
  endtask

  // One CPU access held for 'hold' clocks after wait_n releases.
  // Called right after step(); viden must have been stable for a cell.
  task automatic cpu_txn(input bit we, input logic [10:0] a, input logic [7:0] wd, input int hold);
    int d;
    logic [7:0] exp_rd;
    exp_rd = '0;
    d = (viden && ph < 3'd2) ? 2 - int'(ph) : 0;
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    for (int i = 0; i < d + 2 + hold; i++) begin
      if (i > 0) step();
      look();
      chk("wait_n", 32'(wait_n), (i < d + 2) ? 32'd0 : 32'd1);
      if (i == d) begin
        chk("mem_addr", 32'(mem_addr), 32'(a));
        chk("mem_we", 32'(mem_we), 32'(we));
        if (we) begin
          chk("mem_wdata", 32'(mem_wdata), 32'(wd));
          model_mem[a] = wd;
        end else begin
          exp_rd = model_mem[a];
        end
      end else begin
        chk("mem_we_quiet", 32'(mem_we), 32'd0);
      end
      if (i == d + 2) begin
        if (!we) last_rd = exp_rd;
        chk("cpu_rdata", 32'(cpu_rdata), 32'(last_rd));
      end
    end
    step();
    cpu_req = 0;
    look();
    chk("wait_n_release", 32'(wait_n), 32'd1);
    chk("mem_we_release", 32'(mem_we), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    ph = 3'd0; cell_phase = 3'd0; rnd_vid = 0;
    f0 = 0; f1 = 0; ld_next = 0; exp_scr = '0; exp_chr = '0; last_rd = '0;
    rst = 1; viden = 0; vid_scr_addr = '0; vid_chr_row = '0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 11'h555; cpu_wdata = 8'hFF;
    ld_en = 0; ld_addr = '0; ld_data = '0;

    // Preload RAM under reset while a CPU write request is held high.
    for (int i = 0; i < 2048; i++) begin
      step();
      ld_en = 1; ld_addr = 11'(i);
      ld_data = (i == 0) ? 8'h85 : (i == 11'h428) ? 8'h3C : 8'($urandom);
      model_mem[i] = ld_data;
      look();
      if (i == 4) begin
        chk("rst_wait_n", 32'(wait_n), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_vid_scr", 32'(vid_scr_data), 32'd0);
        chk("rst_vid_chr", 32'(vid_chr_data), 32'd0);
        chk("rst_vid_load", 32'(vid_load), 32'd0);
      end
      if (i == 8) cpu_req = 0;
    end
    step(); rst = 0; ld_en = 0; look();

    // Test 1: cell fetch of screen 0x000 -> char 0x428.
    viden = 1;
    idle(9);
    go_to(3'd3);
    look();
    chk("t1_load", 32'(vid_load), 32'd1);
    chk("t1_scr", 32'(vid_scr_data), 32'h85);
    chk("t1_chr", 32'(vid_chr_data), 32'h3C);

    // Test 2: read raised at phase 0 waits for phase 2, wait_n low 4 clk.
    go_to(3'd0);
    cpu_txn(0, 11'h123, 8'h00, 1);

    // Test 4: read at phase 7 overlapping the next video fetch.
    rnd_vid = 1;
    go_to(3'd7);
    cpu_txn(0, 11'h456, 8'h00, 2);
    idle(4);

    // Test 3: write then readback outside the display.
    viden = 0;
    idle(10);
    step(); cpu_txn(1, 11'h7FF, 8'hA5, 1);
    step(); cpu_txn(0, 11'h7FF, 8'h00, 1);
    chk("t3_readback", 32'(cpu_rdata), 32'hA5);

    // Test 6: long hold after one read and after one write.
    step(); cpu_txn(0, 11'h2B7, 8'h00, 20);
    step(); cpu_txn(1, 11'h0C3, 8'h5A, 20);

    // Test 5: reset while the write is in CAPT.
    step();
    cpu_req = 1; cpu_we = 1; cpu_addr = 11'h3AA; cpu_wdata = 8'h5C;
    look();
    chk("t5_issue_we", 32'(mem_we), 32'd1);
    model_mem[11'h3AA] = 8'h5C;
    step(); rst = 1; look();
    chk("t5_rst_wait_n", 32'(wait_n), 32'd1);
    chk("t5_rst_mem_we", 32'(mem_we), 32'd0);
    chk("t5_rst_mem_addr", 32'(mem_addr), 32'd0);
    step(); rst = 0; cpu_req = 0; look();
    chk("t5_post_wait_n", 32'(wait_n), 32'd1);
    chk("t5_post_mem_we", 32'(mem_we), 32'd0);
    chk("t5_post_rdata", 32'(cpu_rdata), 32'd0);
    chk("t5_post_vscr", 32'(vid_scr_data), 32'd0);
    chk("t5_post_vchr", 32'(vid_chr_data), 32'd0);
    last_rd = '0;
    step(); cpu_txn(0, 11'h3AA, 8'h00, 1);

    // viden falling after phase 0 still completes; rising mid-cell does nothing.
    viden = 1;
    idle(9);
    go_to(3'd0); look();
    step(); viden = 0; look();
    idle(10);
    go_to(3'd3); viden = 1; look();
    idle(14);

    // Randomized traffic in blocks with and without active display.
    for (int blk = 0; blk < 6; blk++) begin
      viden = blk[0];
      idle(10);
      for (int t = 0; t < 25; t++) begin
        idle(int'($urandom_range(0, 7)));
        step();
        cpu_txn(1'($urandom), 11'($urandom), 8'($urandom), int'($urandom_range(1, 3)));
      end
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
